dct_block_scheduler: RTL and testbench

- Shares the single 8x8 DCT engine in the jfpjc compressor between NUM_BUFFERS block buffers filled from the hm01b0 row stream.
- Picks a ready buffer round-robin and drives the 64 sequential fetch addresses into the selected buffer EBR.
- Flags valid/last for the engine's input and pulses a release back to the buffer owner once the block has been consumed.
- Sits between the camera-side block buffers and the DCT/quantizer/Huffman pipeline.

---
 rtl/dct_block_scheduler.sv | 132 +++++++++++++
 tb/tb_dct_block_scheduler.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dct_block_scheduler.sv
// Round-robin arbiter sharing one 8x8 DCT engine between several block buffers:
// grants a ready buffer, walks its 64 fetch addresses and pulses a release when done.
module dct_block_scheduler #(
   parameter int NUM_BUFFERS = 5,
   parameter int SEL_WIDTH   = 3,
   parameter int COUNT_WIDTH = 16
) (
   input  logic                   clock,
   input  logic                   nreset,
   input  logic                   sof,
   input  logic [NUM_BUFFERS-1:0] buf_ready,
   output logic [NUM_BUFFERS-1:0] buf_release,
   output logic [SEL_WIDTH-1:0]   sel,
   output logic [5:0]             fetch_addr,
   output logic                   fetch_valid,
   input  logic                   dct_stall,
   output logic                   data_valid,
   output logic                   data_last,
   output logic                   busy,
   output logic [COUNT_WIDTH-1:0] block_count
);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_FETCH   = 2'd1;
   localparam logic [1:0] S_DRAIN   = 2'd2;
   localparam logic [1:0] S_RELEASE = 2'd3;

   logic [1:0]             state;
   logic [SEL_WIDTH-1:0]   rr;
   logic [NUM_BUFFERS-1:0] mask;
   logic                   pending_sof;

   logic [NUM_BUFFERS-1:0] eligible;
   logic [NUM_BUFFERS-1:0] sel_onehot;
   logic [SEL_WIDTH-1:0]   search_ptr;
   logic [SEL_WIDTH-1:0]   grant_idx;
   logic                   grant_found;
   logic [SEL_WIDTH-1:0]   next_rr;
   logic                   accepted;

   assign eligible    = buf_ready & ~mask;
   assign sel_onehot  = NUM_BUFFERS'(1) << sel;
   assign search_ptr  = sof ? '0 : rr;
   assign next_rr     = (sel == SEL_WIDTH'(NUM_BUFFERS - 1)) ? '0 : sel + SEL_WIDTH'(1);
   assign accepted    = (state == S_FETCH) && fetch_valid && !dct_stall;
   assign busy        = (state != S_IDLE);
   assign buf_release = (state == S_RELEASE) ? sel_onehot : '0;

   // First eligible index at or above the search pointer, wrapping modulo NUM_BUFFERS.
   always_comb begin
      logic [SEL_WIDTH:0]     cand;
      logic [NUM_BUFFERS-1:0] shifted;
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = '0;
      shifted     = '0;
      for (int unsigned i = 0; i < NUM_BUFFERS; i++) begin
         cand = {1'b0, search_ptr} + (SEL_WIDTH+1)'(i);
         if (cand >= (SEL_WIDTH+1)'(NUM_BUFFERS)) begin
            cand = cand - (SEL_WIDTH+1)'(NUM_BUFFERS);
         end
         shifted = eligible >> cand;
         if (!grant_found && shifted[0]) begin
            grant_found = 1'b1;
            grant_idx   = cand[SEL_WIDTH-1:0];
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!nreset) begin
         state       <= S_IDLE;
         sel         <= '0;
         rr          <= '0;
         mask        <= '0;
         pending_sof <= 1'b0;
         fetch_addr  <= '0;
         fetch_valid <= 1'b0;
         data_valid  <= 1'b0;
         data_last   <= 1'b0;
         block_count <= '0;
      end else begin
         data_valid <= accepted;
         data_last  <= accepted && (fetch_addr == 6'd63);
         mask       <= '0;
         case (state)
            S_IDLE: begin
               if (sof) begin
                  block_count <= '0;
                  rr          <= '0;
               end
               if (grant_found) begin
                  sel         <= grant_idx;
                  fetch_addr  <= '0;
                  fetch_valid <= 1'b1;
                  state       <= S_FETCH;
               end
            end
            S_FETCH: begin
               if (sof) pending_sof <= 1'b1;
               if (accepted) begin
                  if (fetch_addr == 6'd63) begin
                     fetch_valid <= 1'b0;
                     state       <= S_DRAIN;
                  end else begin
                     fetch_addr <= fetch_addr + 6'd1;
                  end
               end
            end
            // Count lands here so the new total is visible alongside the release pulse.
            S_DRAIN: begin
               if (sof) pending_sof <= 1'b1;
               if (block_count != '1) block_count <= block_count + COUNT_WIDTH'(1);
               state <= S_RELEASE;
            end
            S_RELEASE: begin
               if (pending_sof || sof) begin
                  block_count <= '0;
                  rr          <= '0;
               end else begin
                  rr <= next_rr;
               end
               pending_sof <= 1'b0;
               mask        <= sel_onehot;
               state       <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dct_block_scheduler.sv
// Bench for dct_block_scheduler: directed scenarios plus random traffic, all
// outputs compared every cycle against a block-level behavioural model.
module tb_dct_block_scheduler;

   localparam int N = 5;

   logic         clock = 1'b0;
   logic         nreset;
   logic         sof;
   logic [N-1:0] buf_ready;
   logic [N-1:0] buf_release;
   logic [2:0]   sel;
   logic [5:0]   fetch_addr;
   logic         fetch_valid;
   logic         dct_stall;
   logic         data_valid;
   logic         data_last;
   logic         busy;
   logic [15:0]  block_count;

   dct_block_scheduler #(.NUM_BUFFERS(N), .SEL_WIDTH(3), .COUNT_WIDTH(16)) dut (
      .clock(clock), .nreset(nreset), .sof(sof), .buf_ready(buf_ready),
      .buf_release(buf_release), .sel(sel), .fetch_addr(fetch_addr),
      .fetch_valid(fetch_valid), .dct_stall(dct_stall), .data_valid(data_valid),
      .data_last(data_last), .busy(busy), .block_count(block_count)
   );

   always #5 clock = ~clock;

   int total_checks = 0;
   int passed_checks = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total_checks++;
      if (got === exp) passed_checks++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
   endtask

   // Model: a granted block is described by how many coefficients were accepted
   // and how many cycles have elapsed after the last one.
   int m_busy, m_cur, m_sel, m_acc, m_post, m_addr, m_rr, m_mask, m_pending, m_count;
   int m_dv, m_dl;
   int last_rel;

   // Observations used by directed scenarios.
   int cyc, first_fv, first_dl, first_rel, dv_seen, rel_count;
   int rel_sel[$];
   int rel_cyc[$];

   task automatic model_reset();
      m_busy = 0; m_cur = 0; m_sel = 0; m_acc = 0; m_post = 0; m_addr = 0;
      m_rr = 0; m_mask = -1; m_pending = 0; m_count = 0; m_dv = 0; m_dl = 0;
   endtask

   task automatic model_update(input logic [N-1:0] rdy, input logic stl, input logic sf, input logic rst_n);
      int found;
      int j;
      if (!rst_n) begin
         model_reset();
         return;
      end
      m_dv = 0;
      m_dl = 0;
      if (m_busy == 0) begin
         if (sf) begin m_count = 0; m_rr = 0; end
         found = 0;
         for (int i = 0; i < N; i++) begin
            j = (m_rr + i) % N;
            if (found == 0 && rdy[j] && j != m_mask) begin
               found = 1;
               m_busy = 1; m_cur = j; m_sel = j; m_acc = 0; m_post = 0; m_addr = 0;
            end
         end
         m_mask = -1;
      end else begin
         m_mask = -1;
         if (m_acc < 64) begin
            if (sf) m_pending = 1;
            if (!stl) begin
               m_dv = 1;
               m_dl = (m_acc == 63) ? 1 : 0;
               m_acc++;
               if (m_addr < 63) m_addr++;
            end
         end else if (m_post == 0) begin
            if (sf) m_pending = 1;
            m_post = 1;
            if (m_count < 65535) m_count++;
         end else begin
            if (m_pending != 0 || sf) begin m_count = 0; m_rr = 0; end
            else m_rr = (m_cur + 1) % N;
            m_pending = 0;
            m_mask = m_cur;
            m_busy = 0;
         end
      end
   endtask

   task automatic step(input logic [N-1:0] rdy, input logic stl, input logic sf, input logic rst_n);
      int exp_rel;
      buf_ready = rdy; dct_stall = stl; sof = sf; nreset = rst_n;
      exp_rel = (m_busy != 0 && m_acc == 64 && m_post == 1) ? (1 << m_cur) : 0;
      check_eq("busy", 32'(busy), m_busy);
      check_eq("sel", 32'(sel), m_sel);
      check_eq("fetch_addr", 32'(fetch_addr), m_addr);
      check_eq("fetch_valid", 32'(fetch_valid), (m_busy != 0 && m_acc < 64) ? 1 : 0);
      check_eq("data_valid", 32'(data_valid), m_dv);
      check_eq("data_last", 32'(data_last), m_dl);
      check_eq("buf_release", 32'(buf_release), exp_rel);
      check_eq("block_count", 32'(block_count), m_count);
      if (fetch_valid && first_fv < 0) first_fv = cyc;
      if (data_last && first_dl < 0) first_dl = cyc;
      if (buf_release != '0) begin
         if (first_rel < 0) first_rel = cyc;
         rel_count = int'(block_count);
         rel_sel.push_back(int'(sel));
         rel_cyc.push_back(cyc);
      end
      if (data_valid) dv_seen++;
      last_rel = exp_rel;
      model_update(rdy, stl, sf, rst_n);
      cyc++;
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      step('0, 1'b0, 1'b0, 1'b0);
      step('0, 1'b0, 1'b0, 1'b0);
      cyc = 0; first_fv = -1; first_dl = -1; first_rel = -1; dv_seen = 0; rel_count = -1;
      rel_sel.delete();
      rel_cyc.delete();
   endtask

   task automatic run_block(input logic [N-1:0] rdy);
      int done;
      done = 0;
      for (int c = 0; c < 400 && done == 0; c++) begin
         step(rdy, 1'b0, 1'b0, 1'b1);
         if (last_rel != 0) done = 1;
      end
      check_eq("block_timeout", done, 1);
   endtask

   task automatic run_to_addr(input logic [N-1:0] rdy, input int addr);
      int hit;
      hit = 0;
      for (int c = 0; c < 200 && hit == 0; c++) begin
         if (m_busy != 0 && m_acc == addr) hit = 1;
         else step(rdy, 1'b0, 1'b0, 1'b1);
      end
      check_eq("addr_timeout", hit, 1);
   endtask

   initial begin
      logic [N-1:0] avail;
      nreset = 1'b0; sof = 1'b0; dct_stall = 1'b0; buf_ready = '0;
      cyc = 0; first_fv = -1; first_dl = -1; first_rel = -1; dv_seen = 0; rel_count = -1;
      repeat (2) @(posedge clock);
      #1;
      model_reset();

      // Single buffer 0: latency from grant to last data and release.
      do_reset();
      run_block(5'b00001);
      check_eq("t1_first_fv", first_fv, 1);
      check_eq("t1_last_lat", first_dl - first_fv, 64);
      check_eq("t1_rel_lat", first_rel - first_fv, 65);
      check_eq("t1_count", 32'(block_count), 1);

      // Three buffers, each owner dropping ready after its release.
      do_reset();
      avail = 5'b10110;
      for (int c = 0; c < 201; c++) begin
         step(avail, 1'b0, 1'b0, 1'b1);
         avail = avail & ~N'(last_rel);
      end
      check_eq("t2_releases", rel_sel.size(), 3);
      if (rel_sel.size() == 3) begin
         check_eq("t2_order0", rel_sel[0], 1);
         check_eq("t2_order1", rel_sel[1], 2);
         check_eq("t2_order2", rel_sel[2], 4);
         check_eq("t2_last_rel_cyc", rel_cyc[2], 200);
      end
      check_eq("t2_count", 32'(block_count), 3);
      check_eq("t2_idle", 32'(busy), 0);

      // Buffer 3 released, owner drops ready, reasserts two cycles later.
      do_reset();
      run_block(5'b01000);
      step('0, 1'b0, 1'b0, 1'b1);
      step('0, 1'b0, 1'b0, 1'b1);
      check_eq("t3_no_regrant", 32'(fetch_valid), 0);
      step(5'b01000, 1'b0, 1'b0, 1'b1);
      check_eq("t3_regrant_fv", 32'(fetch_valid), 1);
      check_eq("t3_regrant_sel", 32'(sel), 3);
      run_block(5'b01000);
      check_eq("t3_count", 32'(block_count), 2);

      // Ten stall cycles at address 20.
      do_reset();
      run_to_addr(5'b00001, 20);
      for (int c = 0; c < 10; c++) begin
         step(5'b00001, 1'b1, 1'b0, 1'b1);
         check_eq("t4_held_addr", 32'(fetch_addr), 20);
      end
      run_block(5'b00001);
      step('0, 1'b0, 1'b0, 1'b1);
      check_eq("t4_dv_pulses", dv_seen, 64);
      check_eq("t4_rel_lat", first_rel - first_fv, 75);

      // Start of frame arriving mid-block on buffer 2.
      do_reset();
      run_to_addr(5'b01100, 30);
      step(5'b01100, 1'b0, 1'b1, 1'b1);
      run_block(5'b01100);
      check_eq("t5_count_at_rel", rel_count, 1);
      check_eq("t5_count_cleared", 32'(block_count), 0);
      step(5'b01100, 1'b0, 1'b0, 1'b1);
      check_eq("t5_next_sel", 32'(sel), 3);
      check_eq("t5_next_fv", 32'(fetch_valid), 1);

      // Reset in the middle of a block.
      do_reset();
      run_to_addr(5'b00001, 40);
      step(5'b00001, 1'b0, 1'b0, 1'b0);
      check_eq("t6_busy", 32'(busy), 0);
      check_eq("t6_fv", 32'(fetch_valid), 0);
      check_eq("t6_addr", 32'(fetch_addr), 0);
      check_eq("t6_release", 32'(buf_release), 0);
      step(5'b00001, 1'b0, 1'b0, 1'b1);
      check_eq("t6_regrant_fv", 32'(fetch_valid), 1);
      check_eq("t6_regrant_addr", 32'(fetch_addr), 0);

      // Random traffic with persistent, occasionally toggling ready lines.
      do_reset();
      avail = '0;
      for (int c = 0; c < 4000; c++) begin
         for (int b = 0; b < N; b++) begin
            if ($urandom_range(0, 7) == 0) avail[b] = ~avail[b];
         end
         step(avail, ($urandom_range(0, 3) == 0), ($urandom_range(0, 149) == 0),
              ($urandom_range(0, 799) != 0));
         avail = avail & ~N'(last_rel);
      end

      $display("%0d/%0d checks passed", passed_checks, total_checks);
      $finish;
   end

endmodule
